// File: rtl/router_1xn.sv
// router_1xn: routes packets from one byte-wide source to NCH output FIFOs.
// Packet = header, LEN payload bytes, parity byte. Header carries the
// destination address in its low AW bits and LEN in the remaining bits.
// A channel left unread for TIMEOUT cycles while non-empty is flushed.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - asynchronous reset, active low
//   pkt_vld  - source byte valid
//   din      - source byte
//   re       - per-channel read enable
//   d_out    - per-channel read data, channel i at [i*DW +: DW]
//   vld_out  - per-channel FIFO non-empty
//   busy     - source must hold din/pkt_vld
//   err      - one-cycle pulse on parity mismatch (during CHECK)
//   drop     - one-cycle pulse after discarding a header with bad address
module router_1xn #(
  parameter int NCH     = 4,
  parameter int DW      = 8,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_vld,
  input  logic [DW-1:0]     din,
  input  logic [NCH-1:0]    re,
  output logic [NCH*DW-1:0] d_out,
  output logic [NCH-1:0]    vld_out,
  output logic              busy,
  output logic              err,
  output logic              drop
);

  localparam int AW = $clog2(NCH);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = DW - AW;
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [AW:0]   NCH_L   = (AW + 1)'(NCH);
  localparam logic [LW-1:0] LEN_ONE = LW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
  localparam logic [PW:0]   DEPTH_L = (PW + 1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_EMPTY, LOAD_DATA, LOAD_PARITY, CHECK, DROP
  } state_t;

  state_t        state;
  logic [AW-1:0] dest;
  logic [LW-1:0] len_tgt;
  logic [LW-1:0] len_cnt;
  logic [DW-1:0] par;
  logic          err_r;
  logic          drop_r;

  logic [NCH-1:0] empty;
  logic [NCH-1:0] full;
  logic [NCH-1:0] flush;

  logic [AW-1:0] hdr_addr;
  logic [LW-1:0] hdr_len;
  logic [LW-1:0] hdr_len_eff;
  logic          hdr_valid;
  logic [AW-1:0] wr_ch;
  logic          load_st;
  logic          accept;
  logic          abort;
  logic          wr_en;

  assign hdr_addr    = din[AW-1:0];
  assign hdr_len     = din[DW-1:AW];
  assign hdr_len_eff = (hdr_len == '0) ? LEN_ONE : hdr_len;
  assign hdr_valid   = {1'b0, hdr_addr} < NCH_L;

  assign load_st = (state == LOAD_DATA) || (state == LOAD_PARITY);

  // busy is purely combinational so a full FIFO stalls the source in the
  // same cycle; a read of a full FIFO frees space only from the next cycle.
  always_comb begin
    busy = 1'b0;
    case (state)
      IDLE:                   busy = pkt_vld && hdr_valid && !empty[hdr_addr];
      WAIT_EMPTY:             busy = !empty[dest];
      LOAD_DATA, LOAD_PARITY: busy = full[dest];
      CHECK:                  busy = 1'b1;
      default:                busy = 1'b0;
    endcase
  end

  assign accept = pkt_vld && !busy;
  // A timeout flush of the channel being loaded kills the rest of the packet.
  assign abort  = load_st && flush[dest];
  assign wr_ch  = (state == IDLE) ? hdr_addr : dest;
  assign wr_en  = accept && !abort &&
                  (((state == IDLE) && hdr_valid) || (state == WAIT_EMPTY) || load_st);

  assign vld_out = ~empty;
  assign err     = err_r;
  assign drop    = drop_r;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      dest    <= '0;
      len_tgt <= '0;
      len_cnt <= '0;
      par     <= '0;
      err_r   <= 1'b0;
      drop_r  <= 1'b0;
    end else begin
      err_r  <= 1'b0;
      drop_r <= 1'b0;
      case (state)
        IDLE: begin
          if (pkt_vld) begin
            if (!hdr_valid) begin
              drop_r <= 1'b1;
              state  <= DROP;
            end else if (accept) begin
              dest    <= hdr_addr;
              len_tgt <= hdr_len_eff;
              len_cnt <= '0;
              par     <= din;
              state   <= LOAD_DATA;
            end else begin
              dest  <= hdr_addr;
              state <= WAIT_EMPTY;
            end
          end
        end
        WAIT_EMPTY: begin
          if (accept) begin
            len_tgt <= hdr_len_eff;
            len_cnt <= '0;
            par     <= din;
            state   <= LOAD_DATA;
          end
        end
        LOAD_DATA: begin
          if (abort) begin
            state <= DROP;
          end else if (accept) begin
            par     <= par ^ din;
            len_cnt <= len_cnt + LEN_ONE;
            if (len_cnt + LEN_ONE == len_tgt) state <= LOAD_PARITY;
          end
        end
        LOAD_PARITY: begin
          if (abort) begin
            state <= DROP;
          end else if (accept) begin
            err_r <= (din != par);
            state <= CHECK;
          end
        end
        CHECK: state <= IDLE;
        DROP:  if (!pkt_vld) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW:0]   cnt;
    logic [TW-1:0] tcnt;
    logic [DW-1:0] dout_r;
    logic          wr_i;
    logic          rd_i;
    logic          idle_i;

    assign empty[i] = (cnt == '0);
    assign full[i]  = (cnt == DEPTH_L);
    assign wr_i     = wr_en && (wr_ch == AW'(i));
    assign rd_i     = re[i] && !empty[i];
    assign idle_i   = !empty[i] && !re[i];
    assign flush[i] = idle_i && (tcnt == TO_LAST);
    assign d_out[i*DW +: DW] = dout_r;

    always_ff @(posedge clk) begin
      if (wr_i) mem[wptr] <= din;
    end

    // Flush only fires with re[i]=0 and never coincides with a write to this
    // channel, so it can simply snap the read pointer to the write pointer.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        wptr   <= '0;
        rptr   <= '0;
        cnt    <= '0;
        tcnt   <= '0;
        dout_r <= '0;
      end else begin
        if (idle_i && !flush[i]) tcnt <= tcnt + TO_ONE;
        else                     tcnt <= '0;
        if (flush[i]) begin
          cnt  <= '0;
          rptr <= wptr;
        end else begin
          if (rd_i) begin
            dout_r <= mem[rptr];
            rptr   <= rptr + PTR_ONE;
          end
          if (wr_i) wptr <= wptr + PTR_ONE;
          case ({wr_i, rd_i})
            2'b10:   cnt <= cnt + CNT_ONE;
            2'b01:   cnt <= cnt - CNT_ONE;
            default: cnt <= cnt;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_router_1xn.sv
// Scoreboard bench for router_1xn: expected bytes are queued per channel when
// the source hands a byte over, and popped when a channel read returns data.
module tb_router_1xn;
  localparam int NCH = 4;
  localparam int DW = 8;
  localparam int DEPTH = 16;
  localparam int TIMEOUT = 30;

  logic              clk = 1'b0;
  logic              rst;
  logic              pkt_vld;
  logic [DW-1:0]     din;
  logic [NCH-1:0]    re;
  logic [NCH*DW-1:0] d_out;
  logic [NCH-1:0]    vld_out;
  logic              busy, err, drop;

  logic        pkt_vld3;
  logic [7:0]  din3;
  logic [2:0]  re3;
  logic [23:0] d_out3;
  logic [2:0]  vld_out3;
  logic        busy3, err3, drop3;

  router_1xn #(.NCH(NCH), .DW(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) u_dut (
    .clk(clk), .rst(rst), .pkt_vld(pkt_vld), .din(din), .re(re),
    .d_out(d_out), .vld_out(vld_out), .busy(busy), .err(err), .drop(drop)
  );

  router_1xn #(.NCH(3), .DW(8), .DEPTH(16), .TIMEOUT(30)) u_dut3 (
    .clk(clk), .rst(rst), .pkt_vld(pkt_vld3), .din(din3), .re(re3),
    .d_out(d_out3), .vld_out(vld_out3), .busy(busy3), .err(err3), .drop(drop3)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] sb [NCH][$];
  logic [7:0] tx [$];
  logic s_busy, s_err, s_drop;
  logic [NCH-1:0] s_vld;

  // One clock: drive at negedge, sample handshake just after, check read data after posedge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic [NCH-1:0] r,
                       output logic acc);
    logic [NCH-1:0] rdm;
    logic [7:0] exp;
    @(negedge clk);
    pkt_vld = v; din = d; re = r;
    #1;
    s_busy = busy; s_err = err; s_drop = drop; s_vld = vld_out;
    acc = v && !busy;
    rdm = r & vld_out;
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (rdm[i]) begin
        vectors++;
        if (sb[i].size() == 0) begin
          miscompares++;
          $display("FAIL read_extra ch%0d: got %h, required no data", i, d_out[i*DW +: DW]);
        end else begin
          exp = sb[i].pop_front();
          if (d_out[i*DW +: DW] !== exp) begin
            miscompares++;
            $display("FAIL read_data ch%0d: got %h, required %h", i, d_out[i*DW +: DW], exp);
          end
        end
      end
    end
  endtask

  task automatic build_pkt(input logic [7:0] hdr, input int len, input logic [7:0] base);
    logic [7:0] p, b;
    tx.delete();
    tx.push_back(hdr);
    p = hdr;
    for (int k = 0; k < len; k++) begin
      b = base + 8'(k * 17);
      tx.push_back(b);
      p = p ^ b;
    end
    tx.push_back(p);
  endtask

  task automatic send_pkt(input int dest, input logic [NCH-1:0] r, output int nbusy);
    logic acc;
    int guard;
    nbusy = 0;
    for (int k = 0; k < tx.size(); k++) begin
      acc = 1'b0;
      guard = 0;
      while (!acc && guard < 200) begin
        cycle(1'b1, tx[k], r, acc);
        if (s_busy) nbusy++;
        guard++;
      end
      if (acc) sb[dest].push_back(tx[k]);
      else begin
        vectors++; miscompares++;
        $display("FAIL send_stall byte %0d: got no accept in 200 cycles, required accept", k);
      end
    end
  endtask

  task automatic drain(input int ch);
    logic acc;
    logic [NCH-1:0] m;
    int n, exp_n;
    m = '0; m[ch] = 1'b1;
    exp_n = sb[ch].size();
    n = 0;
    for (int k = 0; k < 64 && vld_out[ch]; k++) begin
      cycle(1'b0, 8'h00, m, acc);
      n++;
    end
    vectors++;
    if (n !== exp_n) begin
      miscompares++;
      $display("FAIL drain_count ch%0d: got %0d, required %0d", ch, n, exp_n);
    end
    vectors++;
    if (vld_out[ch] !== 1'b0) begin
      miscompares++;
      $display("FAIL drain_empty ch%0d: got vld %b, required 0", ch, vld_out[ch]);
    end
  endtask

  task automatic check_cycle(input string name, input logic [NCH-1:0] r, input logic exp_err);
    logic acc;
    cycle(1'b0, 8'h00, r, acc);
    vectors++;
    if (s_busy !== 1'b1) begin
      miscompares++; $display("FAIL %s_check_busy: got %b, required 1", name, s_busy);
    end
    vectors++;
    if (s_err !== exp_err) begin
      miscompares++; $display("FAIL %s_check_err: got %b, required %b", name, s_err, exp_err);
    end
    cycle(1'b0, 8'h00, r, acc);
    vectors++;
    if (s_busy !== 1'b0 || s_err !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_after_check: got busy %b err %b, required 0 0", name, s_busy, s_err);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; pkt_vld = 1'b0; din = '0; re = '0;
    pkt_vld3 = 1'b0; din3 = '0; re3 = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (d_out !== '0 || vld_out !== '0 || busy !== 1'b0 || err !== 1'b0 || drop !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got d_out %h vld %b busy %b err %b drop %b, required all 0",
               d_out, vld_out, busy, err, drop);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_good_packet;
    int nb;
    build_pkt(8'h0D, 3, 8'h11);
    send_pkt(1, '0, nb);
    vectors++;
    if (nb !== 0) begin
      miscompares++; $display("FAIL good_load_busy: got %0d busy cycles, required 0", nb);
    end
    vectors++;
    if (vld_out !== 4'b0010) begin
      miscompares++; $display("FAIL good_vld: got %b, required 0010", vld_out);
    end
    check_cycle("good", '0, 1'b0);
    drain(1);
  endtask

  task automatic test_bad_parity;
    int nb;
    build_pkt(8'h0D, 3, 8'h11);
    tx[4] = 8'h00;
    send_pkt(1, '0, nb);
    check_cycle("badpar", '0, 1'b1);
    drain(1);
  endtask

  task automatic test_back_to_back;
    int nb;
    build_pkt(8'h0D, 3, 8'h11);
    send_pkt(1, '0, nb);
    build_pkt(8'h09, 2, 8'h40);
    send_pkt(1, 4'b0010, nb);
    vectors++;
    if (nb !== 5) begin
      miscompares++; $display("FAIL b2b_wait_busy: got %0d busy cycles, required 5", nb);
    end
    check_cycle("b2b", 4'b0010, 1'b0);
    drain(1);
  endtask

  task automatic test_backpressure;
    logic acc;
    logic [NCH-1:0] r;
    int idx, stall, first_busy;
    idx = 0; stall = 0; first_busy = -1;
    build_pkt(8'h50, 20, 8'h01);
    for (int c = 0; c < 300 && idx < tx.size(); c++) begin
      r = (stall >= 3) ? NCH'(1) : '0;
      cycle(1'b1, tx[idx], r, acc);
      if (acc) begin
        sb[0].push_back(tx[idx]);
        idx++;
      end else if (s_busy) begin
        if (first_busy < 0) first_busy = idx;
        stall++;
      end
    end
    vectors++;
    if (idx !== 22) begin
      miscompares++; $display("FAIL bp_accepted: got %0d, required 22", idx);
    end
    vectors++;
    if (first_busy !== DEPTH) begin
      miscompares++; $display("FAIL bp_full_at: got %0d, required %0d", first_busy, DEPTH);
    end
    vectors++;
    if (stall !== 4) begin
      miscompares++; $display("FAIL bp_stall_cycles: got %0d, required 4", stall);
    end
    check_cycle("bp", NCH'(1), 1'b0);
    drain(0);
  endtask

  task automatic test_timeout;
    logic acc;
    int nb, n;
    build_pkt(8'h06, 1, 8'hA5);
    send_pkt(2, '0, nb);
    check_cycle("to", '0, 1'b0);
    cycle(1'b0, 8'h00, 4'b0100, acc);
    n = 0;
    for (int k = 0; k < 100; k++) begin
      cycle(1'b0, 8'h00, '0, acc);
      if (!s_vld[2]) break;
      n++;
    end
    vectors++;
    if (n !== TIMEOUT) begin
      miscompares++; $display("FAIL timeout_cycles: got %0d, required %0d", n, TIMEOUT);
    end
    vectors++;
    if (d_out[2*DW +: DW] !== 8'h06) begin
      miscompares++; $display("FAIL timeout_dout_hold: got %h, required 06", d_out[2*DW +: DW]);
    end
    vectors++;
    if (vld_out !== '0) begin
      miscompares++; $display("FAIL timeout_vld: got %b, required 0000", vld_out);
    end
    sb[2].delete();
  endtask

  task automatic test_invalid_addr;
    logic [7:0] seq [4];
    logic exp_drop [4];
    seq[0] = 8'h07; seq[1] = 8'hAA; seq[2] = 8'h55; seq[3] = 8'h00;
    exp_drop[0] = 1'b0; exp_drop[1] = 1'b1; exp_drop[2] = 1'b0; exp_drop[3] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      pkt_vld3 = (k < 3); din3 = seq[k];
      #1;
      vectors++;
      if (busy3 !== 1'b0 || drop3 !== exp_drop[k]) begin
        miscompares++;
        $display("FAIL inv_step%0d: got busy %b drop %b, required busy 0 drop %b",
                 k, busy3, drop3, exp_drop[k]);
      end
    end
    @(posedge clk);
    #1;
    vectors++;
    if (vld_out3 !== 3'b000 || drop3 !== 1'b0) begin
      miscompares++;
      $display("FAIL inv_no_write: got vld %b drop %b, required 000 0", vld_out3, drop3);
    end
  endtask

  task automatic test_reset_mid;
    logic acc;
    int nb;
    build_pkt(8'h13, 4, 8'h60);
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, tx[k], '0, acc);
      if (acc) sb[3].push_back(tx[k]);
    end
    @(negedge clk);
    rst = 1'b0; pkt_vld = 1'b0;
    #1;
    vectors++;
    if (d_out !== '0 || vld_out !== '0 || busy !== 1'b0 || err !== 1'b0 || drop !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset_outputs: got d_out %h vld %b busy %b err %b drop %b, required all 0",
               d_out, vld_out, busy, err, drop);
    end
    for (int i = 0; i < NCH; i++) sb[i].delete();
    @(negedge clk);
    rst = 1'b1;
    build_pkt(8'h13, 4, 8'h60);
    send_pkt(3, '0, nb);
    vectors++;
    if (nb !== 0) begin
      miscompares++; $display("FAIL midreset_load_busy: got %0d, required 0", nb);
    end
    check_cycle("midreset", '0, 1'b0);
    drain(3);
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_invalid_addr();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
